pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage RV32I pipeline. It drives the stop and flush inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard sources:
- load-use dependencies,
- data-memory wait states,
- taken branches or jumps resolved in EX, with extra wrong-path flushes to cover synchronous instruction-fetch latency.

## Interface
- FETCH_LAT, 1: wrong-path fetches still arriving after a redirect (0–3); each costs one extra IF/ID flush cycle.
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1 each  the instruction in ID reads rs1 / rs2
- ex_mem_read  in  1  the instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  EX redirects the PC this cycle
- mem_req  in  1  MEM stage has an outstanding data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- pc_stop, if_id_stop, id_ex_stop, ex_mem_stop  out  1 each  hold the register
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (zero) into the register
- state  out  2  0=RUN, 1=REDIRECT, 2=MEM_WAIT (3 unused)
- stall_cycles, flush_cycles  out  32 each  performance counters (see Configuration)

## Operation
- All outputs are combinational from state, redirect counter rcnt[1:0] and the inputs. state and rcnt are the only sequential elements, apart from the optional counters.
- While rst_n=0: all stop/flush outputs are 0, state=RUN, rcnt=0, and both counters are 0.
- Hazard priority, highest first: memory wait, branch redirect, load-use.
- **Memory wait:** mw = mem_req & ~mem_ready.
  - When mw=1: pc_stop, if_id_stop, id_ex_stop and ex_mem_stop are all 1, mem_wb_flush=1, and every other output is 0.
  - Next state is MEM_WAIT.
- **Branch redirect:** when mw=0 and ex_branch_taken=1: if_id_flush=1 and id_ex_flush=1.
  - rcnt loads FETCH_LAT.
  - Next state is REDIRECT if FETCH_LAT≠0, otherwise RUN.
- **Load-use:** lu = ex_mem_read & (ex_rd≠0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - lu applies only in RUN, or in the MEM_WAIT release cycle, when there is no mw and no branch.
  - When it applies: pc_stop=1, if_id_stop=1 and id_ex_flush=1 for exactly one cycle; state stays RUN.
  - The following cycle, MEM forwarding resolves the dependency.
- **REDIRECT state:**
  - Without mw or branch: if_id_flush=1 and rcnt decrements; when rcnt==1, the next state is RUN.
  - lu is suppressed, since ID holds a bubble.
  - A new ex_branch_taken reloads rcnt to FETCH_LAT and flushes both IF/ID and ID/EX.
- **MEM_WAIT state:**
  - While mw=1, stay in MEM_WAIT with rcnt held.
  - On mem_ready=1 (the release cycle), all stalls drop and branch/load-use rules are evaluated as in RUN.
  - If no branch occurs in the release cycle: next state is REDIRECT when rcnt≠0, else RUN. Only in the REDIRECT case does the release cycle also assert if_id_flush.
- mem_req=1 with mem_ready=1 in the same cycle causes no stall.

## Timing
- Stall and flush outputs take effect in the same cycle as the causing input. There is no registered delay.
- Load-use penalty: 1 cycle.
- Taken-branch penalty: 2+FETCH_LAT cycles.
- Memory wait: the stall lasts exactly the number of cycles with mem_req=1 and mem_ready=0.
- rst_n asserted mid-operation (any state, any rcnt): outputs return to 0 immediately, and state=RUN on the first cycle after release.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cycles increments every cycle in which pc_stop=1.
  - flush_cycles increments every cycle in which if_id_flush=1.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear only on reset.
- HAZARD_PERF_EN undefined: both ports are tied to 32'h0 and no counter flops exist.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_used=1 → one cycle of pc_stop=1, if_id_stop=1 and id_ex_flush=1, then all 0.
  - Same stimulus with ex_rd=0 → no stall.
- FETCH_LAT=1, ex_branch_taken pulse → cycle 0: if_id_flush=1 and id_ex_flush=1, state→REDIRECT. Cycle 1: if_id_flush=1 only, then state=RUN.
- mem_req=1 with mem_ready low for 3 cycles, then high → exactly 3 cycles with all four stops and mem_wb_flush=1; state=2 during the wait, RUN after.
- mw and ex_branch_taken together, then release → only the stall appears during the wait; the redirect flush appears in the release cycle, followed by REDIRECT for FETCH_LAT cycles.
- rst_n pulsed low while in REDIRECT with rcnt=1 → outputs 0 asynchronously, state=0.
  - With HAZARD_PERF_EN, after a 3-cycle memory stall from reset → stall_cycles=3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage RV32I pipeline (load-use, memory wait, EX redirect).
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
   parameter int unsigned FETCH_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rd,
   input  logic        ex_branch_taken,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        pc_stop,
   output logic        if_id_stop,
   output logic        id_ex_stop,
   output logic        ex_mem_stop,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        mem_wb_flush,
   output logic [1:0]  state,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_cycles
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_t;

   localparam logic [1:0] FETCH_LAT_C = FETCH_LAT[1:0];

   state_t     state_r, state_nxt_s;
   logic [1:0] rcnt_r, rcnt_nxt_s;
   logic       mw_s, lu_s;

   assign mw_s = mem_req & ~mem_ready;
   assign lu_s = ex_mem_read & (ex_rd != 5'd0) &
                 ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));

   // State and redirect counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_RUN;
         rcnt_r  <= 2'd0;
      end else begin
         state_r <= state_nxt_s;
         rcnt_r  <= rcnt_nxt_s;
      end
   end

   // Hazard resolution: outputs and next state, gated to zero during reset
   always_comb begin
      pc_stop      = 1'b0;
      if_id_stop   = 1'b0;
      id_ex_stop   = 1'b0;
      ex_mem_stop  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      state_nxt_s  = state_r;
      rcnt_nxt_s   = rcnt_r;
      if (!rst_n) begin
         state_nxt_s = ST_RUN;
         rcnt_nxt_s  = 2'd0;
      end else if (mw_s) begin
         pc_stop      = 1'b1;
         if_id_stop   = 1'b1;
         id_ex_stop   = 1'b1;
         ex_mem_stop  = 1'b1;
         mem_wb_flush = 1'b1;
         state_nxt_s  = ST_MEM_WAIT;
      end else if (ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         rcnt_nxt_s  = FETCH_LAT_C;
         state_nxt_s = (FETCH_LAT_C != 2'd0) ? ST_REDIRECT : ST_RUN;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (lu_s) begin
                  pc_stop     = 1'b1;
                  if_id_stop  = 1'b1;
                  id_ex_flush = 1'b1;
               end else begin
                  pc_stop     = 1'b0;
               end
               state_nxt_s = ST_RUN;
            end
            ST_REDIRECT: begin
               if_id_flush = 1'b1;
               rcnt_nxt_s  = rcnt_r - 2'd1;
               if (rcnt_r <= 2'd1) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_REDIRECT;
               end
            end
            ST_MEM_WAIT: begin
               // A pending redirect means ID still holds a wrong-path bubble, so load-use is moot
               if (rcnt_r != 2'd0) begin
                  if_id_flush = 1'b1;
                  state_nxt_s = ST_REDIRECT;
               end else if (lu_s) begin
                  pc_stop     = 1'b1;
                  if_id_stop  = 1'b1;
                  id_ex_flush = 1'b1;
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            default: begin
               state_nxt_s = ST_RUN;
               rcnt_nxt_s  = 2'd0;
            end
         endcase
      end
   end

   assign state = state_r;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_r, flush_cnt_r;

   // Performance counters, free-running with natural wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= 32'd0;
         flush_cnt_r <= 32'd0;
      end else begin
         stall_cnt_r <= stall_cnt_r + {31'd0, pc_stop};
         flush_cnt_r <= flush_cnt_r + {31'd0, if_id_flush};
      end
   end

   assign stall_cycles = stall_cnt_r;
   assign flush_cycles = flush_cnt_r;
`else
   assign stall_cycles = 32'h0;
   assign flush_cycles = 32'h0;
`endif

endmodule
